decoder_scan_sequencer: RTL and testbench
=========================================

// Module: decoder_scan_sequencer
// PURPOSE
//   Upstream driver for the 2-to-4 active-low line decoder. Sweeps the four
//   decoder channels round-robin and drives address {A,B} plus active-low
//   enable. Channels can be masked. Supports continuous or single-sweep mode.
//   Address changes only while enable is high, so decoder outputs never glitch.
// PARAMETERS
//   DWELL  4  cycles enable is held low per channel (legal range 1..255)
//   BLANK  1  cycles enable is held high before each channel (0..255; 0 = none)
//   CW     8  width of the internal dwell/blank counter
// PORTS
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   start     in   1  begin sweep; honoured only in IDLE
//   stop      in   1  abort sweep; honoured in any state
//   one_shot  in   1  1 = single sweep then IDLE; 0 = continuous; sampled at start
//   mask      in   4  channel enables; bit i = channel i; sampled as below
//   A         out  1  decoder address MSB (channel index bit 1)
//   B         out  1  decoder address LSB (channel index bit 0)
//   enable    out  1  active-low decoder enable (0 = selected D[i] low)
//   busy      out  1  high in BLANK/DRIVE
//   done      out  1  one-cycle pulse at end of a one_shot sweep
// BEHAVIOUR
//   - All outputs are registered. Reset values: A=0, B=0, enable=1, busy=0,
//     done=0, state=IDLE, counter=0, mask latch=0.
//   - States: IDLE, BLANK, DRIVE. enable=0 only in DRIVE.
//   - IDLE: start=1, stop=0, mask!=0 -> latch mask and one_shot; load {A,B} with
//     the lowest set mask bit; go BLANK (DRIVE if BLANK=0); busy=1 next cycle.
//     start with mask==0 is ignored, with no done pulse.
//   - BLANK: hold for BLANK cycles, then DRIVE.
//   - DRIVE: hold for DWELL cycles. Next channel = next set latched-mask bit
//     above the current index, wrapping 3->0.
//   - Wrap: the next index is <= the current index, including a single-channel mask.
//     - If one_shot: go IDLE, done=1 for one cycle, and busy=0 in that same cycle.
//     - Otherwise: re-latch live mask and continue. If the live mask is 0, go
//       IDLE with no done pulse.
//   - Latency: start sampled at edge N. BLANK is cycles N+1..N+BLANK. enable=0
//     from N+1+BLANK for DWELL cycles.
//   - Channel period = BLANK+DWELL cycles. {A,B} is stable throughout BLANK and DRIVE.
//     {A,B} updates only on entry to BLANK (or DRIVE if BLANK=0).
//     If BLANK=0, back-to-back channels switch address in the same edge that
//     keeps enable low; this is permitted only with BLANK=0.
//   - stop has priority over start and over every transition. The next cycle
//     has enable=1, busy=0, IDLE, no done. {A,B} hold their last value.
//   - start while busy: ignored. Live mask changes mid-sweep: take effect
//     at the next wrap only.
//   - rst_n low at any time: immediately forces reset values (async). Operation
//     resumes only on a new start after rst_n is released.
//   - Counter: CW bits, counts down from DWELL-1 or BLANK-1 to 0. No
//     arithmetic overflow is possible within the legal range.
// TESTING
//   1 reset: rst_n=0 mid-DRIVE -> enable=1, A=B=0, busy=0 immediately.
//   2 mask=4'b1111, one_shot=1, DWELL=4, BLANK=1, start at edge 0:
//     - enable low on cycles 2-5 with {A,B}=00, 7-10 with 01, 12-15 with 10,
//       and 17-20 with 11.
//     - done=1 on cycle 21; busy=0 from cycle 21.
//   3 mask=4'b1010, one_shot=0 -> channel sequence 1,3,1,3,...;
//     {A,B} never 00 or 10 while enable=0.
//   4 stop asserted on cycle 3 of test 2 -> cycle 4: enable=1, busy=0,
//     no done; a new start restarts at channel 0.
//   5 start with mask=0 -> stays IDLE, busy=0, done=0. start pulsed while busy
//     -> sequence unchanged.
//   6 one_shot=0 with mask changed 4'b1111->4'b0100 mid-sweep -> finishes
//     channels to 3, then channel 2 only. Mask set to 0 -> IDLE at wrap.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// Round-robin scan driver for a 2-to-4 active-low decoder. The address only
// moves while enable is high (unless BLANK=0), so decoder outputs never glitch.
module decoder_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int BLANK = 1,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       one_shot,
  input  logic [3:0] mask,
  output logic       A,
  output logic       B,
  output logic       enable,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = (BLANK == 0) ? CW'(0) : CW'(BLANK - 1);
  // Every channel is entered through BLANK, or straight into DRIVE when BLANK=0.
  localparam state_t        ENTRY_ST = (BLANK == 0) ? S_DRIVE : S_BLANK;
  localparam logic [CW-1:0] ENTRY_LD = (BLANK == 0) ? DWELL_LD : BLANK_LD;

  state_t        state, n_state;
  logic [CW-1:0] cnt, n_cnt;
  logic [1:0]    idx, n_idx;
  logic [3:0]    mask_q, n_mask;
  logic          os_q, n_os;
  logic          done_ev;
  logic          n_enable, n_busy, n_done;
  logic          above_found;
  logic [1:0]    above_idx;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowest = 2'(i);
  endfunction

  // Next latched channel strictly above the current one; none found means wrap.
  always_comb begin
    above_found = 1'b0;
    above_idx   = idx;
    for (int i = 0; i < 4; i++)
      if (!above_found && (2'(i) > idx) && mask_q[i]) begin
        above_found = 1'b1;
        above_idx   = 2'(i);
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= 2'd0;
      mask_q <= 4'd0;
      os_q   <= 1'b0;
      enable <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= n_state;
      cnt    <= n_cnt;
      idx    <= n_idx;
      mask_q <= n_mask;
      os_q   <= n_os;
      enable <= n_enable;
      busy   <= n_busy;
      done   <= n_done;
    end
  end

  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_idx   = idx;
    n_mask  = mask_q;
    n_os    = os_q;
    done_ev = 1'b0;
    if (stop) begin
      n_state = S_IDLE;
      n_cnt   = '0;
    end else begin
      case (state)
        S_IDLE:
          if (start && (mask != 4'd0)) begin
            n_mask  = mask;
            n_os    = one_shot;
            n_idx   = lowest(mask);
            n_state = ENTRY_ST;
            n_cnt   = ENTRY_LD;
          end
        S_BLANK:
          if (cnt == '0) begin
            n_state = S_DRIVE;
            n_cnt   = DWELL_LD;
          end else begin
            n_cnt = cnt - 1'b1;
          end
        S_DRIVE:
          if (cnt != '0) begin
            n_cnt = cnt - 1'b1;
          end else if (above_found) begin
            n_idx   = above_idx;
            n_state = ENTRY_ST;
            n_cnt   = ENTRY_LD;
          end else if (os_q) begin
            n_state = S_IDLE;
            n_cnt   = '0;
            done_ev = 1'b1;
          end else if (mask != 4'd0) begin
            // Continuous wrap: the live mask is picked up only here.
            n_mask  = mask;
            n_idx   = lowest(mask);
            n_state = ENTRY_ST;
            n_cnt   = ENTRY_LD;
          end else begin
            n_state = S_IDLE;
            n_cnt   = '0;
          end
        default: begin
          n_state = S_IDLE;
          n_cnt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    n_enable = (n_state != S_DRIVE);
    n_busy   = (n_state != S_IDLE);
    n_done   = done_ev;
  end

  assign A = idx[1];
  assign B = idx[0];

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer (DWELL=4, BLANK=1): a cycle table
// for the one-shot sweep plus hand-written stop/reset/mask sequences.
module tb_decoder_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, stop, one_shot;
  logic [3:0] mask;
  logic       A, B, enable, busy, done;

  int errors = 0;
  int checks = 0;

  decoder_scan_sequencer #(.DWELL(4), .BLANK(1), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .one_shot(one_shot),
    .mask(mask), .A(A), .B(B), .enable(enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       en;
    logic [1:0] ab;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t       vt[14];
  logic       en_c[0:31];
  logic [1:0] ab_c[0:31];
  logic       busy_c[0:31];
  logic       done_c[0:31];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-shot sweep of all four channels; records cycles 1..22 after the start edge.
  task automatic run_sweep(input int pulse_at);
    mask = 4'hF; one_shot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      en_c[c] = enable; ab_c[c] = {A, B}; busy_c[c] = busy; done_c[c] = done;
      start = (c == pulse_at);
      if (c == pulse_at) mask = 4'b0010;
      tick();
    end
    start = 1'b0;
    mask  = 4'hF;
  endtask

  task automatic check_sweep(input string tag);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("%s c%0d enable", tag, vt[i].cyc), 32'(en_c[vt[i].cyc]), 32'(vt[i].en));
      chk($sformatf("%s c%0d addr", tag, vt[i].cyc), 32'(ab_c[vt[i].cyc]), 32'(vt[i].ab));
      chk($sformatf("%s c%0d busy", tag, vt[i].cyc), 32'(busy_c[vt[i].cyc]), 32'(vt[i].bsy));
      chk($sformatf("%s c%0d done", tag, vt[i].cyc), 32'(done_c[vt[i].cyc]), 32'(vt[i].dn));
    end
  endtask

  initial begin
    int seq[8];
    int n, bad, dn_cnt;
    logic prev_en;
    logic went_idle;

    vt[0]  = '{1, 1'b1, 2'b00, 1'b1, 1'b0};
    vt[1]  = '{2, 1'b0, 2'b00, 1'b1, 1'b0};
    vt[2]  = '{5, 1'b0, 2'b00, 1'b1, 1'b0};
    vt[3]  = '{6, 1'b1, 2'b01, 1'b1, 1'b0};
    vt[4]  = '{7, 1'b0, 2'b01, 1'b1, 1'b0};
    vt[5]  = '{10, 1'b0, 2'b01, 1'b1, 1'b0};
    vt[6]  = '{11, 1'b1, 2'b10, 1'b1, 1'b0};
    vt[7]  = '{12, 1'b0, 2'b10, 1'b1, 1'b0};
    vt[8]  = '{15, 1'b0, 2'b10, 1'b1, 1'b0};
    vt[9]  = '{16, 1'b1, 2'b11, 1'b1, 1'b0};
    vt[10] = '{17, 1'b0, 2'b11, 1'b1, 1'b0};
    vt[11] = '{20, 1'b0, 2'b11, 1'b1, 1'b0};
    vt[12] = '{21, 1'b1, 2'b11, 1'b0, 1'b1};
    vt[13] = '{22, 1'b1, 2'b11, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0; mask = 4'h0;
    tick(); tick();
    chk("reset enable", 32'(enable), 32'd1);
    chk("reset addr", 32'({A, B}), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // One-shot full sweep timing.
    run_sweep(0);
    check_sweep("sweep");

    // start pulsed mid-sweep (with a live mask change) must not disturb it.
    tick();
    run_sweep(4);
    check_sweep("busy_start");

    // start with an empty mask is ignored.
    tick();
    mask = 4'h0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mask0 busy", 32'(busy), 32'd0);
    chk("mask0 enable", 32'(enable), 32'd1);
    tick();
    chk("mask0 busy later", 32'(busy), 32'd0);
    chk("mask0 done", 32'(done), 32'd0);

    // stop on cycle 3: cycle 4 is idle with no done.
    mask = 4'hF; one_shot = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop c4 enable", 32'(enable), 32'd1);
    chk("stop c4 busy", 32'(busy), 32'd0);
    chk("stop c4 done", 32'(done), 32'd0);
    tick();
    chk("stop after done", 32'(done), 32'd0);
    chk("stop after busy", 32'(busy), 32'd0);

    // stop during channel 1 holds the address; restart goes back to channel 0.
    start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop hold addr", 32'({A, B}), 32'b01);
    chk("stop hold enable", 32'(enable), 32'd1);
    tick();
    start = 1'b1;
    tick(); start = 1'b0;
    chk("restart c1 addr", 32'({A, B}), 32'b00);
    chk("restart c1 busy", 32'(busy), 32'd1);
    tick();
    chk("restart c2 enable", 32'(enable), 32'd0);
    chk("restart c2 addr", 32'({A, B}), 32'b00);
    stop = 1'b1; tick(); stop = 1'b0;

    // Continuous sweep over mask 1010: channels 1,3,1,3 only.
    mask = 4'b1010; one_shot = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    n = 0; bad = 0; prev_en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (!enable && (B == 1'b0)) bad++;
      if (prev_en && !enable && n < 8) begin seq[n] = int'({A, B}); n++; end
      prev_en = enable;
      tick();
    end
    chk("cont1010 bad addr", 32'(bad), 32'd0);
    chk("cont1010 entries", 32'(n >= 4), 32'd1);
    if (n >= 4) begin
      chk("cont1010 ch0", 32'(seq[0]), 32'd1);
      chk("cont1010 ch1", 32'(seq[1]), 32'd3);
      chk("cont1010 ch2", 32'(seq[2]), 32'd1);
      chk("cont1010 ch3", 32'(seq[3]), 32'd3);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("cont stop busy", 32'(busy), 32'd0);

    // Live mask change mid-sweep only lands at the wrap; mask 0 ends at next wrap.
    mask = 4'hF; one_shot = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    n = 0; prev_en = 1'b1;
    for (int c = 1; c <= 60 && n < 6; c++) begin
      if (prev_en && !enable) begin seq[n] = int'({A, B}); n++; end
      prev_en = enable;
      if (c == 8) mask = 4'b0100;
      tick();
    end
    chk("livemask entries", 32'(n), 32'd6);
    if (n == 6) begin
      chk("livemask ch0", 32'(seq[0]), 32'd0);
      chk("livemask ch1", 32'(seq[1]), 32'd1);
      chk("livemask ch2", 32'(seq[2]), 32'd2);
      chk("livemask ch3", 32'(seq[3]), 32'd3);
      chk("livemask ch4", 32'(seq[4]), 32'd2);
      chk("livemask ch5", 32'(seq[5]), 32'd2);
    end
    mask = 4'h0;
    dn_cnt = 0; went_idle = 1'b0;
    for (int c = 0; c < 20 && !went_idle; c++) begin
      tick();
      if (done) dn_cnt++;
      if (!busy) went_idle = 1'b1;
    end
    chk("mask0 wrap idle", 32'(went_idle), 32'd1);
    chk("mask0 wrap no done", 32'(dn_cnt), 32'd0);
    tick();
    chk("mask0 wrap done after", 32'(done), 32'd0);

    // Asynchronous reset mid-DRIVE acts without a clock edge.
    mask = 4'hF; one_shot = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    chk("pre-reset enable", 32'(enable), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async enable", 32'(enable), 32'd1);
    chk("async addr", 32'({A, B}), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post-reset busy", 32'(busy), 32'd0);
    chk("post-reset enable", 32'(enable), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
